serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor: diff = a - b - bin, with borrow-out. It is the inverse-direction companion of the team's combinational multibit adder.
- Processes one bit per clock, LSB first, through a single registered borrow.
- Valid/ready handshakes on both the operand side and the result side, so it can drop into streaming datapaths where area matters more than latency.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a/b/bin valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  diff/bout valid
- out_ready  input  1  downstream accepts result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned)

Behaviour:
- Clocking and reset:
  - Single clock domain. All state is updated only on the rising edge of clk.
  - rst has priority over everything, including mid-operation. It discards any in-flight operation and any pending result.
  - Reset values: state=IDLE, diff=0, bout=0, out_valid=0, internal shift registers, borrow and bit counter = 0.
  - in_ready is decoded from state, so it is 1 in the cycle after the reset edge.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: latch a, b and bin into shift registers/borrow flop, clear the counter, go to SHIFT.
  - in_valid=0: stay in IDLE.
- SHIFT:
  - in_ready=0, out_valid=0. Operands presented in this state are ignored.
  - Each edge: d_bit = a0 ^ b0 ^ brw; brw_next = (~a0 & b0) | (~(a0 ^ b0) & brw).
  - d_bit shifts into the MSB of the diff shift register; the operand registers shift right; the counter increments.
  - After exactly WIDTH SHIFT edges: bout <= final brw, go to DONE.
- DONE:
  - out_valid=1. diff and bout are held stable until the handshake completes.
  - On an edge with out_ready=1: go to IDLE and clear out_valid.
  - No same-cycle re-accept. in_ready rises in the following cycle.
- Latency and throughput:
  - Accept edge at T gives out_valid=1 in the cycle after edge T+WIDTH.
  - Minimum spacing between operations: WIDTH+2 cycles.
- Backpressure: out_ready may stay low indefinitely. The result is held and no new operand is accepted.
- Width rules: diff wraps modulo 2^WIDTH. bout is the unsigned borrow.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0), registered together with bout on entry to DONE.
  - ovf = signed two's-complement overflow = (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]), using the latched operand MSBs.
  - ovf follows the same hold rules as bout.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package/header serial_sub_pkg:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
  - default WIDTH constant
  - counter width function clog2(WIDTH+1)
- One natural sub-module, full_subtractor_bit: combinational a, b, bin -> d, bo. It is instantiated once and feeds the borrow flop.
- The FSM, counter and shift registers stay in the top level.

Test Plan:
- Basic subtract, no borrow. a=0111, b=0011, bin=0, out_ready=1 -> diff=0100, bout=0. out_valid rises exactly 4 edges after the accept edge.
- Borrow-out. a=0011, b=0100, bin=0 -> diff=1111, bout=1. Then a=1100, b=0011, bin=1 -> diff=1000, bout=0.
- Backpressure. out_ready=0 for 10 cycles after DONE -> diff/bout stable, in_ready=0 throughout, a new in_valid pulse is ignored. out_ready=1 -> IDLE next edge, in_ready=1 the cycle after.
- Operands changed mid-SHIFT. Start a=0101, b=0001, then drive a=1111, b=1111 in SHIFT -> result still diff=0100, bout=0.
- Reset mid-operation. rst=1 on the 2nd SHIFT edge -> next cycle state IDLE, out_valid=0, diff=0000, bout=0, in_ready=1. A following operation a=1010, b=0101 gives diff=0101.
- With SERIAL_SUB_OVF_EN:
  - a=1000, b=0001, bin=0 -> diff=0111, bout=0, ovf=1.
  - a=0010, b=0001 -> ovf=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the bit-counter sizing helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bo_o
);

    // Borrow when a < b + bin for this bit position.
    always_comb begin
        d_o  = a_i ^ b_i ^ bin_i;
        bo_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock,
// with valid/ready handshakes on the operand and result sides.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic             brw_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bout_q;
    logic             out_valid_q;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q;
`endif

    logic d_bit;
    logic brw_d;

    full_subtractor_bit u_fs (
        .a_i   (a_q[0]),
        .b_i   (b_q[0]),
        .bin_i (brw_q),
        .d_o   (d_bit),
        .bo_o  (brw_d)
    );

    // Handshake and result outputs decoded from registered state.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = out_valid_q;
        diff      = diff_q;
        bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf       = ovf_q;
`endif
    end

    // FSM, operand/result shift registers, borrow flop and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            brw_q       <= 1'b0;
            cnt_q       <= '0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        brw_q   <= bin;
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    diff_q <= {d_bit, diff_q[WIDTH-1:1]};
                    a_q    <= a_q >> 1;
                    b_q    <= b_q >> 1;
                    brw_q  <= brw_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        bout_q      <= brw_d;
                        out_valid_q <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last bit a_q[0]/b_q[0] are the latched operand MSBs
                        // and d_bit is the result MSB.
                        ovf_q       <= (a_q[0] ^ b_q[0]) & (a_q[0] ^ d_bit);
`endif
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4).
module tb_serial_subtractor;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf       (ovf),
`endif
        .bout      (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand set from IDLE, then count edges until out_valid (bounded).
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                         output int cycles);
        a        = ta;
        b        = tb_v;
        bin      = tbin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cycles   = 0;
        while (out_valid !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (diff !== 4'b0000 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_result: got diff=%b bout=%b expected 0000/0", diff, bout);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int cyc;
        out_ready = 1'b1;
        do_op(4'b0111, 4'b0011, 1'b0, cyc);
        n_checks++;
        if (cyc !== 4) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges expected 4", cyc);
        end
        n_checks++;
        if (diff !== 4'b0100 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got diff=%b bout=%b expected 0100/0", diff, bout);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_return_idle: got out_valid=%b in_ready=%b expected 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_borrow();
        int cyc;
        out_ready = 1'b1;
        do_op(4'b0011, 4'b0100, 1'b0, cyc);
        n_checks++;
        if (cyc !== 4 || diff !== 4'b1111 || bout !== 1'b1) begin
            n_fail++;
            $display("FAIL borrow_out: got cyc=%0d diff=%b bout=%b expected 4/1111/1",
                     cyc, diff, bout);
        end
        tick();
        do_op(4'b1100, 4'b0011, 1'b1, cyc);
        n_checks++;
        if (cyc !== 4 || diff !== 4'b1000 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL borrow_in: got cyc=%0d diff=%b bout=%b expected 4/1000/0",
                     cyc, diff, bout);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad;
        out_ready = 1'b0;
        do_op(4'b0111, 4'b0011, 1'b0, cyc);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            // New operands offered mid-stall must be ignored.
            in_valid = (i == 3);
            a        = 4'b1111;
            b        = 4'b0001;
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 4'b0100 || bout !== 1'b0)
                bad++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (cyc !== 4 || bad !== 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: got cyc=%0d bad_cycles=%0d expected 4/0", cyc, bad);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: got out_valid=%b in_ready=%b expected 0/1",
                     out_valid, in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_no_ghost: got out_valid=%b in_ready=%b expected 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_mid_shift_change();
        int cyc;
        out_ready = 1'b1;
        a         = 4'b0101;
        b         = 4'b0001;
        bin       = 1'b0;
        in_valid  = 1'b1;
        tick();
        a   = 4'b1111;
        b   = 4'b1111;
        bin = 1'b1;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (cyc !== 4 || diff !== 4'b0100 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_shift_change: got cyc=%0d diff=%b bout=%b expected 4/0100/0",
                     cyc, diff, bout);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_shift_idle: got in_ready=%b out_valid=%b expected 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        out_ready = 1'b1;
        // Leave a nonzero result behind so the reset has something to clear.
        do_op(4'b0011, 4'b0100, 1'b0, cyc);
        tick();
        a        = 4'b0110;
        b        = 4'b0001;
        bin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_op_ctrl: got in_ready=%b out_valid=%b expected 1/0",
                     in_ready, out_valid);
        end
        n_checks++;
        if (diff !== 4'b0000 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_op_result: got diff=%b bout=%b expected 0000/0", diff, bout);
        end
        do_op(4'b1010, 4'b0101, 1'b0, cyc);
        n_checks++;
        if (cyc !== 4 || diff !== 4'b0101 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_op_after: got cyc=%0d diff=%b bout=%b expected 4/0101/0",
                     cyc, diff, bout);
        end
        tick();
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        int cyc;
        out_ready = 1'b1;
        do_op(4'b1000, 4'b0001, 1'b0, cyc);
        n_checks++;
        if (diff !== 4'b0111 || bout !== 1'b0 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got diff=%b bout=%b ovf=%b expected 0111/0/1", diff, bout, ovf);
        end
        tick();
        do_op(4'b0010, 4'b0001, 1'b0, cyc);
        n_checks++;
        if (diff !== 4'b0001 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got diff=%b ovf=%b expected 0001/0", diff, ovf);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_backpressure();
        test_mid_shift_change();
        test_reset_mid_op();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
